// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared VGA stream types, sprite geometry and ROM address packing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int CNT_W    = 11;
    localparam int RGB_W    = 12;
    localparam int SPRITE_W = 64;
    localparam int SPRITE_H = 64;

    localparam logic [RGB_W-1:0] KEY_RGB = 12'hF0F;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } vga_bus_t;

    function automatic logic [11:0] rom_addr_pack(input logic [5:0] y, input logic [5:0] x);
        return {y, x};
    endfunction

endpackage

`default_nettype wire

// File: rtl/draw_player_sprite_if.sv
// ============================================================================
// Module  : draw_player_sprite_if
// Brief   : Address/data link between the sprite reader and the image ROM.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface draw_player_sprite_if;
    import vga_pkg::*;

    logic [11:0]      rom_addr;
    logic [RGB_W-1:0] rom_rgb;

    modport master (output rom_addr, input rom_rgb);
    modport slave  (input rom_addr, output rom_rgb);
endinterface

`default_nettype wire

// File: rtl/vga_delay.sv
// ============================================================================
// Module  : vga_delay
// Brief   : DEPTH-stage shift register for the VGA timing/colour bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire vga_bus_t din,
    output vga_bus_t      dout
);

    vga_bus_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/draw_player_sprite.sv
// ============================================================================
// Module  : draw_player_sprite
// Brief   : Overlays a 64x64 ROM sprite on the VGA stream, 3-clock latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module draw_player_sprite
    import vga_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [CNT_W-1:0] hcount_in,
    input  wire logic [CNT_W-1:0] vcount_in,
    input  wire logic             hsync_in,
    input  wire logic             vsync_in,
    input  wire logic             hblnk_in,
    input  wire logic             vblnk_in,
    input  wire logic [RGB_W-1:0] rgb_in,
    input  wire logic [11:0]      xpos,
    input  wire logic [11:0]      ypos,
    input  wire logic             facing_left,
    draw_player_sprite_if.master  rom,
    output logic [CNT_W-1:0]      hcount_out,
    output logic [CNT_W-1:0]      vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [RGB_W-1:0]      rgb_out
);

    logic        vsync_q;
    logic [11:0] xpos_q;
    logic [11:0] ypos_q;
    logic        face_q;

    // Position is sampled only on the vsync rising edge so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            face_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            if (vsync_in && !vsync_q) begin
                xpos_q <= xpos;
                ypos_q <= ypos;
                face_q <= facing_left;
            end
        end
    end

    // 13-bit bounds keep a right/bottom-clipped sprite from wrapping around.
    logic [12:0] w_h, w_v, w_x_lo, w_y_lo, w_x_hi, w_y_hi;
    logic        w_in_spr;
    logic [5:0]  w_rel_x, w_rel_y, w_addr_x;

    assign w_h      = {2'b00, hcount_in};
    assign w_v      = {2'b00, vcount_in};
    assign w_x_lo   = {1'b0, xpos_q};
    assign w_y_lo   = {1'b0, ypos_q};
    assign w_x_hi   = w_x_lo + 13'(SPRITE_W);
    assign w_y_hi   = w_y_lo + 13'(SPRITE_H);
    assign w_in_spr = (w_h >= w_x_lo) && (w_h < w_x_hi) &&
                      (w_v >= w_y_lo) && (w_v < w_y_hi) &&
                      !hblnk_in && !vblnk_in;

    // Only the low six bits of the offset address the ROM.
    assign w_rel_x  = hcount_in[5:0] - xpos_q[5:0];
    assign w_rel_y  = vcount_in[5:0] - ypos_q[5:0];
    assign w_addr_x = face_q ? (6'd63 - w_rel_x) : w_rel_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom.rom_addr <= '0;
        end else if (w_in_spr) begin
            rom.rom_addr <= rom_addr_pack(w_rel_y, w_addr_x);
        end
    end

    logic [ROM_LAT:0] r_in_spr_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_spr_sr <= '0;
        end else begin
            r_in_spr_sr <= {r_in_spr_sr[ROM_LAT-1:0], w_in_spr};
        end
    end

    vga_bus_t w_bus_in, w_bus_d2;

    assign w_bus_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                        vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    vga_delay #(.DEPTH(ROM_LAT + 1)) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (w_bus_in),
        .dout  (w_bus_d2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= w_bus_d2.hcount;
            vcount_out <= w_bus_d2.vcount;
            hsync_out  <= w_bus_d2.hsync;
            vsync_out  <= w_bus_d2.vsync;
            hblnk_out  <= w_bus_d2.hblnk;
            vblnk_out  <= w_bus_d2.vblnk;
            if (w_bus_d2.hblnk || w_bus_d2.vblnk) begin
                rgb_out <= '0;
            end else if (r_in_spr_sr[ROM_LAT] && (rom.rom_rgb != KEY_RGB)) begin
                rgb_out <= rom.rom_rgb;
            end else begin
                rgb_out <= w_bus_d2.rgb;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_draw_player_sprite.sv
// ============================================================================
// Module  : tb_draw_player_sprite
// Brief   : Randomised bench for draw_player_sprite against a pixel-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_draw_player_sprite;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic        facing_left;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    draw_player_sprite_if rom_if ();

    logic [11:0] rom_mem [4096];
    always @(posedge clk) rom_if.rom_rgb <= rom_mem[rom_if.rom_addr];

    draw_player_sprite dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hblnk_in    (hblnk_in),
        .vblnk_in    (vblnk_in),
        .rgb_in      (rgb_in),
        .xpos        (xpos),
        .ypos        (ypos),
        .facing_left (facing_left),
        .rom         (rom_if),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .hblnk_out   (hblnk_out),
        .vblnk_out   (vblnk_out),
        .rgb_out     (rgb_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: a frame-latched sprite position and an expected-output queue.
    typedef struct {
        logic [10:0] h, v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } exp_t;

    exp_t        q[$];
    int          m_x, m_y;
    bit          m_face, m_vs_prev;
    logic [11:0] m_addr;

    task automatic reset_model();
        exp_t z;
        z = '{h: 0, v: 0, hs: 0, vs: 0, hb: 0, vb: 0, rgb: 0};
        m_x = 0; m_y = 0; m_face = 0; m_vs_prev = 0; m_addr = 0;
        q.delete();
        q.push_back(z);
        q.push_back(z);
    endtask

    // Called at a negedge; applies one pixel, checks after the next posedge, ends at a negedge.
    task automatic drive(input int h, input int v, input bit hs, input bit vs,
                         input bit hb, input bit vb, input logic [11:0] rgb);
        exp_t e, o;
        int   col, row;
        logic [11:0] word, addr;
        hcount_in = 11'(h); vcount_in = 11'(v);
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        e = '{h: 11'(h), v: 11'(v), hs: hs, vs: vs, hb: hb, vb: vb, rgb: rgb};
        if (hb || vb) begin
            e.rgb = 12'h000;
        end else if (h >= m_x && h < m_x + 64 && v >= m_y && v < m_y + 64) begin
            col  = h - m_x;
            row  = v - m_y;
            if (m_face) col = 63 - col;
            addr = 12'(row * 64 + col);
            m_addr = addr;
            word = rom_mem[addr];
            if (word != 12'hF0F) e.rgb = word;
        end
        if (vs && !m_vs_prev) begin
            m_x = int'(xpos); m_y = int'(ypos); m_face = facing_left;
        end
        m_vs_prev = vs;
        q.push_back(e);
        @(posedge clk); #1;
        o = q.pop_front();
        check("rom_addr", rom_if.rom_addr, m_addr);
        check("hcount", hcount_out, o.h);
        check("vcount", vcount_out, o.v);
        check("hsync", hsync_out, o.hs);
        check("vsync", vsync_out, o.vs);
        check("hblnk", hblnk_out, o.hb);
        check("vblnk", vblnk_out, o.vb);
        check("rgb", rgb_out, o.rgb);
        @(negedge clk);
    endtask

    task automatic rand_pix(input int hlo, input int hhi, input int vlo, input int vhi);
        drive($urandom_range(hhi, hlo), $urandom_range(vhi, vlo), 1'($urandom),
              1'b0, ($urandom % 12) == 0, ($urandom % 12) == 0, 12'($urandom));
    endtask

    task automatic vsync_pulse(input int x, input int y, input bit f);
        xpos = 12'(x); ypos = 12'(y); facing_left = f;
        drive(0, 600, 0, 0, 1, 1, 12'($urandom));
        drive(0, 601, 0, 1, 1, 1, 12'($urandom));
        drive(0, 602, 0, 1, 1, 1, 12'($urandom));
        drive(0, 603, 0, 0, 1, 1, 12'($urandom));
    endtask

    task automatic reset_phase(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            hcount_in = 11'($urandom); vcount_in = 11'($urandom);
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
            rgb_in = 12'($urandom); xpos = 12'($urandom); ypos = 12'($urandom);
            facing_left = 1'($urandom);
            @(posedge clk); #1;
            check("rst_addr", rom_if.rom_addr, 12'h000);
            check("rst_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'h0);
            check("rst_rgb", rgb_out, 12'h000);
            @(negedge clk);
        end
        rst_n = 1'b1;
        reset_model();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            rom_mem[i] = (($urandom % 5) == 0) ? 12'hF0F : 12'($urandom);
        end
        rom_mem[12'h0CA] = 12'hABC;
        rom_mem[12'h0F5] = 12'hF0F;
        rom_if.rom_rgb = 12'h000;

        @(negedge clk);
        reset_phase(5);

        // Unmirrored hit at (110,53) with sprite at (100,50).
        vsync_pulse(100, 50, 0);
        drive(110, 53, 0, 0, 0, 0, 12'h123);
        check("hit_addr", rom_if.rom_addr, 12'h0CA);
        for (int i = 0; i < 300; i++) rand_pix(90, 170, 40, 120);

        // Mirrored: key colour shows background, blanking forces black.
        vsync_pulse(100, 50, 1);
        drive(110, 53, 0, 0, 0, 0, 12'h123);
        check("mirror_addr", rom_if.rom_addr, 12'h0F5);
        drive(110, 53, 0, 0, 1, 0, 12'h123);
        drive(0, 0, 0, 0, 0, 0, 12'h456);
        drive(0, 0, 0, 0, 0, 0, 12'h456);
        check("blank_rgb", rgb_out, 12'h000);
        for (int i = 0; i < 300; i++) rand_pix(90, 170, 40, 120);

        // Right-edge clipping across the 800-pixel active line.
        vsync_pulse(780, 100, 0);
        for (int h = 770; h <= 850; h++) drive(h, 110, 0, 0, h >= 800, 0, 12'($urandom));
        for (int i = 0; i < 300; i++) rand_pix(700, 1100, 90, 170);

        // Bottom clipping and far-off sprites.
        vsync_pulse(300, 580, 1);
        for (int i = 0; i < 300; i++) rand_pix(280, 380, 560, 700);
        vsync_pulse(4090, $urandom_range(700, 0), 0);
        for (int i = 0; i < 300; i++) rand_pix(0, 2047, 0, 2047);

        // Mid-frame position change only takes effect after the next vsync edge.
        vsync_pulse(100, 50, 0);
        xpos = 12'd200;
        for (int i = 0; i < 300; i++) rand_pix(90, 280, 40, 120);
        vsync_pulse(200, 50, 0);
        for (int i = 0; i < 300; i++) rand_pix(90, 280, 40, 120);

        // Mid-frame reset returns the sprite to the origin.
        reset_phase(2);
        for (int i = 0; i < 200; i++) rand_pix(0, 100, 0, 100);

        for (int f = 0; f < 6; f++) begin
            vsync_pulse($urandom_range(820, 0), $urandom_range(620, 0), 1'($urandom));
            for (int i = 0; i < 300; i++) rand_pix(0, 900, 0, 700);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
